// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: pops one byte, strobes txclk, then follows the
// synchronised txready through accept (low) and completion (high) before the next byte.
module uart_tx_queue #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [7:0]             txdata,
    output logic                   txclk,
    input  logic                   txready,
    output logic [1:0]             fsm_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

    // Debug encoding on fsm_state: 0 IDLE, 1 STROBE, 2 WAIT_LO, 3 WAIT_HI.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            rdy_meta;
    logic            rdy_s;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [TW-1:0]   timer;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;

    assign fsm_state = state;
    assign push      = wr_en && !full;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            rdy_meta <= txready;
            rdy_s    <= rdy_meta;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && rdy_s) begin
                    pop        = 1'b1;
                    state_next = STROBE;
                end
            end
            STROBE: state_next = WAIT_LO;
            WAIT_LO: begin
                // Acceptance beats the timeout when both happen in the same cycle.
                if (!rdy_s) begin
                    state_next = WAIT_HI;
                end else if (timer == TIMER_MAX) begin
                    state_next = STROBE;
                end
            end
            WAIT_HI: begin
                if (rdy_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            txclk <= 1'b0;
        end else begin
            state <= state_next;
            txclk <= (state_next == STROBE);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer <= '0;
        end else if (state == STROBE) begin
            timer <= '0;
        end else if (state == WAIT_LO && timer != TIMER_MAX) begin
            timer <= timer + TW'(1);
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            txdata <= 8'h00;
        end else begin
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                txdata <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: driver tasks push bytes into an expected queue, a monitor
// pops it on each new txclk strobe, and a small UART model answers strobes with a frame.
module tb_uart_tx_queue;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 255;
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_HI = 2'd3;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          ovf_clr = 1'b0;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    txdata;
    logic          txclk;
    logic          txready;
    logic [1:0]    fsm_state;

    // UART model: either a level set by the stimulus, or an automatic responder.
    logic uart_auto = 1'b0;
    logic rdy_level = 1'b1;
    logic auto_rdy  = 1'b1;
    int   busy_cnt  = 0;
    assign txready = uart_auto ? auto_rdy : rdy_level;

    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         strobe_cnt = 0;
    logic       have_strobed = 1'b0;
    logic       low_seen = 1'b1;
    logic       prev_txclk = 1'b0;
    logic [7:0] prev_txdata = 8'h00;
    logic [7:0] last_byte = 8'h00;

    uart_tx_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .ovf_clr(ovf_clr), .txdata(txdata), .txclk(txclk), .txready(txready),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Called just after a rising edge; the byte is offered on the next edge.
    task automatic push_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_txdata"},   32'(txdata),    32'(0));
        check({tag, "_txclk"},    32'(txclk),     32'(0));
        check({tag, "_full"},     32'(full),      32'(0));
        check({tag, "_empty"},    32'(empty),     32'(1));
        check({tag, "_count"},    32'(count),     32'(0));
        check({tag, "_overflow"}, 32'(overflow),  32'(0));
        check({tag, "_state"},    32'(fsm_state), 32'(ST_IDLE));
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && empty && fsm_state == ST_IDLE && txready) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drain_in_time"}, 32'(n < budget), 32'(1));
    endtask

    // Monitor: a strobe not preceded by a txready low is a retry of the previous byte.
    always @(negedge clk) begin
        if (!n_rst) begin
            have_strobed = 1'b0;
            low_seen     = 1'b1;
            prev_txclk   = 1'b0;
            prev_txdata  = 8'h00;
        end else begin
            if (txclk) begin
                strobe_cnt++;
                check("txclk_one_cycle", 32'(prev_txclk), 32'(0));
                if (have_strobed && !low_seen) begin
                    check("retry_same_byte", 32'(txdata), 32'(last_byte));
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got byte %0h expected no strobe", txdata);
                end else begin
                    check("tx_order", 32'(txdata), 32'(exp_q.pop_front()));
                end
                last_byte    = txdata;
                have_strobed = 1'b1;
                low_seen     = 1'b0;
            end else begin
                check("txdata_stable", 32'(txdata), 32'(prev_txdata));
                if (!txready) low_seen = 1'b1;
            end
            prev_txclk  = txclk;
            prev_txdata = txdata;
        end
    end

    always @(negedge clk) begin
        if (!uart_auto) begin
            auto_rdy = 1'b1;
            busy_cnt = 0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) auto_rdy = 1'b1;
        end else if (txclk) begin
            auto_rdy = 1'b0;
            busy_cnt = $urandom_range(30, 8);
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int s0;
        int n;
        int g;
        int overlaps;
        logic [7:0] b;

        // Reset defaults, then idle with txready high must not strobe.
        repeat (3) tick();
        sample();
        check_reset("por");
        tick();
        n_rst = 1'b1;
        s0 = strobe_cnt;
        repeat (20) tick();
        check("idle_no_strobe", 32'(strobe_cnt), 32'(s0));

        // Single byte timing.
        push_byte(8'h41);
        sample();
        check("single_count", 32'(count), 32'(1));
        check("single_empty", 32'(empty), 32'(0));
        sample();
        check("single_txclk_hi", 32'(txclk), 32'(1));
        check("single_txdata", 32'(txdata), 32'(8'h41));
        sample();
        check("single_txclk_lo", 32'(txclk), 32'(0));
        s0 = strobe_cnt;
        tick();
        rdy_level = 1'b0;
        repeat (100) tick();
        rdy_level = 1'b1;
        repeat (3) tick();
        check("single_back_idle", 32'(fsm_state), 32'(ST_IDLE));
        repeat (10) tick();
        check("single_no_restrobe", 32'(strobe_cnt), 32'(s0));

        // Fill to full, overflow, set-wins-over-clear, then drain in order.
        rdy_level = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        sample();
        check("fill_full", 32'(full), 32'(1));
        check("fill_count", 32'(count), 32'(16));
        tick();
        push_byte(8'hAA);
        sample();
        check("ovf_set", 32'(overflow), 32'(1));
        check("ovf_count_kept", 32'(count), 32'(16));
        tick();
        ovf_clr = 1'b1;
        push_byte(8'hBB);
        ovf_clr = 1'b0;
        sample();
        check("ovf_set_wins", 32'(overflow), 32'(1));
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        sample();
        check("ovf_cleared", 32'(overflow), 32'(0));
        tick();
        uart_auto = 1'b1;
        wait_drain("order", 3000);

        // Stream with a push landing on each pop edge, across pointer wraps.
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(255, 0)));
        overlaps = 0;
        n = 0;
        while (overlaps < 40 && n < 4000) begin
            if (fsm_state == ST_IDLE && !empty) begin
                b = 8'($urandom_range(255, 0));
                push_byte(b);
                sample();
                check("overlap_count", 32'(count), 32'(exp_q.size()));
                overlaps++;
                tick();
            end else begin
                tick();
            end
            n++;
        end
        check("stream_overlaps", 32'(overlaps), 32'(40));
        wait_drain("stream", 3000);

        // Timeout: txready never drops, the same byte is strobed again.
        uart_auto = 1'b0;
        rdy_level = 1'b1;
        tick();
        s0 = strobe_cnt;
        push_byte(8'h5A);
        push_byte(8'h6B);
        n = 0;
        while (strobe_cnt == s0 && n < 50) begin
            sample();
            n++;
        end
        check("timeout_first_strobe", 32'(n < 50), 32'(1));
        s0 = strobe_cnt;
        g = 0;
        while (strobe_cnt == s0 && g < 600) begin
            sample();
            g++;
        end
        check("timeout_low_cycles", 32'(g - 1), 32'(TIMEOUT + 1));
        check("timeout_count", 32'(count), 32'(exp_q.size()));
        tick();
        uart_auto = 1'b1;
        wait_drain("timeout", 3000);

        // Reset while waiting for frame completion with bytes queued.
        uart_auto = 1'b0;
        rdy_level = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) push_byte(8'(8'h80 + i));
        rdy_level = 1'b0;
        n = 0;
        while (fsm_state != ST_WAIT_HI && n < 50) begin
            tick();
            n++;
        end
        check("midframe_reached_wait_hi", 32'(n < 50), 32'(1));
        check("midframe_count", 32'(count), 32'(exp_q.size()));
        n_rst = 1'b0;
        exp_q.delete();
        sample();
        check_reset("midrst");
        tick();
        rdy_level = 1'b1;
        tick();
        n_rst = 1'b1;
        s0 = strobe_cnt;
        repeat (20) tick();
        check("midrst_no_strobe", 32'(strobe_cnt), 32'(s0));
        check("midrst_count", 32'(count), 32'(0));
        check("midrst_empty", 32'(empty), 32'(1));
        uart_auto = 1'b1;
        push_byte(8'h77);
        wait_drain("after_reset", 1000);

        check("final_queue_empty", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
